// File: rtl/vga_sync_decoder_if.sv
// Raster bundle between a VGA sync source (raw HS/VS) and vga_sync_decoder.
// master = source/consumer side, slave = decoder side.
interface vga_sync_decoder_if;
   logic        hs_in;
   logic        vs_in;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        de;
   logic        frame_start;
   logic        locked;
   logic [11:0] line_len;
   logic [10:0] frame_lines;
   logic        hs_pol;
   logic        vs_pol;

   modport master (
      output hs_in, vs_in,
      input  x, y, de, frame_start, locked, line_len, frame_lines, hs_pol, vs_pol
   );

   modport slave (
      input  hs_in, vs_in,
      output x, y, de, frame_start, locked, line_len, frame_lines, hs_pol, vs_pol
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers raster position, line/frame geometry and lock from raw VGA HS/VS.
// Optional feature macro: VGA_SYNC_AUTOPOL_EN (per-line/per-frame sync polarity detection).
//
// state  | meaning
// SEARCH | no usable timing; first VS edge starts tracking
// TRACK  | comparing each frame's geometry to the previous one
// LOCKED | LOCK_FRAMES consecutive matching frames seen; de enabled
module vga_sync_decoder #(
   parameter int H_OFFSET    = 144,
   parameter int H_ACTIVE    = 640,
   parameter int V_OFFSET    = 35,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input logic               clock_25,
   input logic               reset_n,
   vga_sync_decoder_if.slave sync
);
   typedef enum logic [1:0] {SEARCH = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

   localparam int          CNT_W = $clog2(LOCK_FRAMES + 1);
   localparam logic [11:0] H_MAX = 12'hfff;
   localparam logic [10:0] V_MAX = 11'h7ff;
   localparam logic [11:0] H_LO  = 12'(H_OFFSET);
   localparam logic [11:0] H_HI  = 12'(H_OFFSET + H_ACTIVE);
   localparam logic [10:0] V_LO  = 11'(V_OFFSET);
   localparam logic [10:0] V_HI  = 11'(V_OFFSET + V_ACTIVE);

   logic hs_meta, hs_sync, hs_dly;
   logic vs_meta, vs_sync, vs_dly;
   logic hs_edge, vs_edge;
   logic hs_edge_c, vs_edge_c;
   logic hs_pol_r, vs_pol_r, pol_change;

   logic [11:0] h, h_nxt, len_new, line_len;
   logic [10:0] v, frame_lines;
   logic        line_err, frame_start, timeout;

   state_t           state, state_nxt;
   logic [22:0]      ref_r, ref_nxt;
   logic [CNT_W-1:0] match_cnt, cnt_nxt, cnt_inc;
   logic             frame_ok;
   logic             in_h, in_v, de_w;

   // Edge detect works on raw synchronized levels so a polarity flip never fakes an edge.
   assign hs_edge_c = hs_pol_r ? (hs_sync & ~hs_dly) : (~hs_sync & hs_dly);
   assign vs_edge_c = vs_pol_r ? (vs_sync & ~vs_dly) : (~vs_sync & vs_dly);

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         hs_meta <= 1'b0;
         hs_sync <= 1'b0;
         hs_dly  <= 1'b0;
         vs_meta <= 1'b0;
         vs_sync <= 1'b0;
         vs_dly  <= 1'b0;
         hs_edge <= 1'b0;
         vs_edge <= 1'b0;
      end else begin
         hs_meta <= sync.hs_in;
         hs_sync <= hs_meta;
         hs_dly  <= hs_sync;
         vs_meta <= sync.vs_in;
         vs_sync <= vs_meta;
         vs_dly  <= vs_sync;
         hs_edge <= hs_edge_c;
         vs_edge <= vs_edge_c;
      end
   end

   always_comb begin
      h_nxt = h;
      if (hs_edge)
         h_nxt = 12'd0;
      else if (h != H_MAX)
         h_nxt = h + 12'd1;
   end

   assign len_new = (h == H_MAX) ? H_MAX : h + 12'd1;
   assign timeout = (h_nxt == H_MAX);

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         h           <= 12'd0;
         v           <= 11'd0;
         line_len    <= 12'd0;
         frame_lines <= 11'd0;
         line_err    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         h           <= h_nxt;
         frame_start <= vs_edge;
         if (hs_edge)
            line_len <= len_new;
         if (vs_edge) begin
            v           <= 11'd0;
            frame_lines <= v;
         end else if (hs_edge && v != V_MAX) begin
            v <= v + 11'd1;
         end
         // A length change in the same cycle as VS is kept for the next frame's verdict.
         if (hs_edge && len_new != line_len)
            line_err <= 1'b1;
         else if (vs_edge)
            line_err <= 1'b0;
      end
   end

`ifdef VGA_SYNC_AUTOPOL_EN
   logic [11:0] hs_high;
   logic [10:0] vs_high;
   logic        hs_pol_nxt, vs_pol_nxt;

   always_comb begin
      hs_pol_nxt = hs_pol_r;
      vs_pol_nxt = vs_pol_r;
      if (hs_edge)
         hs_pol_nxt = (hs_high < (len_new >> 1));
      if (vs_edge)
         vs_pol_nxt = (vs_high < (v >> 1));
   end

   assign pol_change = (hs_pol_nxt != hs_pol_r) || (vs_pol_nxt != vs_pol_r);

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         hs_pol_r <= 1'b0;
         vs_pol_r <= 1'b0;
         hs_high  <= 12'd0;
         vs_high  <= 11'd0;
      end else begin
         hs_pol_r <= hs_pol_nxt;
         vs_pol_r <= vs_pol_nxt;
         if (hs_edge)
            hs_high <= {11'd0, hs_sync};
         else if (hs_sync && hs_high != H_MAX)
            hs_high <= hs_high + 12'd1;
         if (vs_edge)
            vs_high <= 11'd0;
         else if (hs_edge && vs_sync && vs_high != V_MAX)
            vs_high <= vs_high + 11'd1;
      end
   end
`else
   assign hs_pol_r   = 1'b0;
   assign vs_pol_r   = 1'b0;
   assign pol_change = 1'b0;
`endif

   assign frame_ok = ({v, line_len} == ref_r) && !line_err;
   assign cnt_inc  = match_cnt + CNT_W'(1);

   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         state     <= SEARCH;
         ref_r     <= 23'd0;
         match_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ref_r     <= ref_nxt;
         match_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ref_nxt   = ref_r;
      cnt_nxt   = match_cnt;
      unique case (state)
         SEARCH: begin
            if (vs_edge) begin
               state_nxt = TRACK;
               ref_nxt   = 23'd0;
               cnt_nxt   = '0;
            end
         end
         TRACK: begin
            if (vs_edge) begin
               ref_nxt = {v, line_len};
               if (frame_ok) begin
                  cnt_nxt = cnt_inc;
                  if (cnt_inc >= CNT_W'(LOCK_FRAMES))
                     state_nxt = LOCKED;
               end else begin
                  cnt_nxt = '0;
               end
            end
         end
         LOCKED: begin
            if ((vs_edge && !frame_ok) || pol_change)
               state_nxt = SEARCH;
         end
         default: state_nxt = SEARCH;
      endcase
      // Losing HS entirely overrides whatever the VS logic decided.
      if (timeout)
         state_nxt = SEARCH;
   end

   assign in_h = (h >= H_LO) && (h < H_HI);
   assign in_v = (v >= V_LO) && (v < V_HI);
   assign de_w = (state == LOCKED) && in_h && in_v;

   assign sync.de          = de_w;
   assign sync.x           = de_w ? 10'(h - H_LO) : 10'd0;
   assign sync.y           = de_w ? 10'(v - V_LO) : 10'd0;
   assign sync.locked      = (state == LOCKED);
   assign sync.frame_start = frame_start;
   assign sync.line_len    = line_len;
   assign sync.frame_lines = frame_lines;
   assign sync.hs_pol      = hs_pol_r;
   assign sync.vs_pol      = vs_pol_r;
endmodule
